// File: rtl/wr_ctrl.sv
// wr_ctrl: write-domain pointer and flag controller for an asynchronous FIFO.
// Keeps the binary write address and the Gray write pointer exported to the
// read domain, and derives full, almost-full, fill level and a sticky overflow
// flag from the read pointer after it has been synchronised into wclk.
module wr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // XOR prefix from the MSB down turns a Gray code back into binary.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr;
  logic          r_wfull;
  logic          r_wafull;
  logic [PW-1:0] r_wlevel;
  logic          r_wovf;

  logic          w_accept;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin_s;
  logic [PW-1:0] w_level_next;
  logic [PW-1:0] w_rptr_full;
  logic          w_full_next;

  // A write is taken only when not full and not in reset; reset masks the
  // RAM enable combinationally so a reset cycle never writes.
  assign w_accept     = winc & ~r_wfull & ~wrst;
  assign w_wbin_next  = r_wbin + {{ADDR_WIDTH{1'b0}}, w_accept};
  assign w_wgray_next = bin2gray(w_wbin_next);

  // The write pointer equals the read pointer with its top two Gray bits
  // inverted exactly when the binary pointers differ by one full depth.
  assign w_rptr_full  = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
  assign w_full_next  = (w_wgray_next == w_rptr_full);

  // Level uses the lagging synchronised read pointer, so it can only
  // overstate the true occupancy, never understate it.
  assign w_rbin_s     = gray2bin(wq2_rptr);
  assign w_level_next = w_wbin_next - w_rbin_s;

  // Register pointers and flags; reset clears every piece of write-side state.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_wbin   <= '0;
      r_wptr   <= '0;
      r_wfull  <= 1'b0;
      r_wafull <= 1'b0;
      r_wlevel <= '0;
      r_wovf   <= 1'b0;
    end else begin
      r_wbin   <= w_wbin_next;
      r_wptr   <= w_wgray_next;
      r_wfull  <= w_full_next;
      r_wafull <= (w_level_next >= AFULL_LVL);
      r_wlevel <= w_level_next;
      r_wovf   <= r_wovf | (winc & r_wfull);
    end
  end

  assign wen          = w_accept;
  assign waddr        = r_wbin[ADDR_WIDTH-1:0];
  assign wptr         = r_wptr;
  assign wfull        = r_wfull;
  assign walmost_full = r_wafull;
  assign wlevel       = r_wlevel;
  assign woverflow    = r_wovf;

endmodule

// File: tb/tb_wr_ctrl.sv
// tb_wr_ctrl: directed bench for wr_ctrl with a count-based reference model.
module tb_wr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int MODP  = 2 * DEPTH;
  localparam int AFULL = 12;

  logic          wclk;
  logic          wrst;
  logic          winc;
  logic [AW:0]   wq2_rptr;
  logic [AW:0]   rptr_drv;
  logic [AW:0]   rp1;
  logic          track;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          woverflow;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Reference model: total accepted writes and derived occupancy.
  int m_wc    = 0;
  int m_lvl   = 0;
  int m_rc    = 0;
  bit m_full  = 1'b0;
  bit m_afull = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_acc   = 1'b0;

  wr_ctrl #(
    .ADDR_WIDTH  (AW),
    .AFULL_THRESH(AFULL)
  ) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .winc        (winc),
    .wq2_rptr    (wq2_rptr),
    .wen         (wen),
    .waddr       (waddr),
    .wptr        (wptr),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .wlevel      (wlevel),
    .woverflow   (woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Read pointer either driven directly or following wptr so that the value
  // produced at edge n-2 is what the DUT sees at edge n.
  assign wq2_rptr = track ? rp1 : rptr_drv;
  always @(posedge wclk) rp1 <= wptr;

  function automatic int gray_of(input int v);
    return (v >> 1) ^ v;
  endfunction

  // Read count recovered by searching for the count whose Gray code matches.
  function automatic int count_of_gray(input int g);
    for (int r = 0; r < MODP; r++) begin
      if (gray_of(r) == g) return r;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Model advances on each clock edge from the occupancy rules.
  always @(posedge wclk) begin
    if (wrst) begin
      m_wc    = 0;
      m_lvl   = 0;
      m_full  = 1'b0;
      m_afull = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      m_acc   = winc && !m_full;
      m_ovf   = m_ovf || (winc && m_full);
      m_wc    = (m_wc + int'(m_acc)) % MODP;
      m_rc    = count_of_gray(int'(wq2_rptr));
      m_lvl   = (m_wc + MODP - m_rc) % MODP;
      m_full  = (m_lvl == DEPTH);
      m_afull = (m_lvl >= AFULL);
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge wclk) begin
    if (chk_en) begin
      chk("wen",          int'(wen),          int'(winc && !m_full && !wrst));
      chk("waddr",        int'(waddr),        m_wc % DEPTH);
      chk("wptr",         int'(wptr),         gray_of(m_wc));
      chk("wfull",        int'(wfull),        int'(m_full));
      chk("walmost_full", int'(walmost_full), int'(m_afull));
      chk("wlevel",       int'(wlevel),       m_lvl);
      chk("woverflow",    int'(woverflow),    int'(m_ovf));
    end
  end

  // Inputs change just after a rising edge; returns at the following falling edge.
  task automatic cycle(input logic r, input logic i, input logic [AW:0] rp);
    @(posedge wclk);
    #1;
    wrst     = r;
    winc     = i;
    rptr_drv = rp;
    @(negedge wclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW:0] gtab [5];
    logic [AW:0] prev;
    gtab     = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd6};
    wrst     = 1'b1;
    winc     = 1'b1;
    rptr_drv = '0;
    track    = 1'b0;

    // reset held with a write request pending
    cycle(1'b1, 1'b1, 5'd0);
    chk("rst_wen", int'(wen), 0);
    cycle(1'b1, 1'b1, 5'd0);
    chk("rst_wen", int'(wen), 0);
    cycle(1'b0, 1'b0, 5'd0);
    chk_en = 1'b1;
    chk("rst_wptr",   int'(wptr),      0);
    chk("rst_wlevel", int'(wlevel),    0);
    chk("rst_wfull",  int'(wfull),     0);
    chk("rst_wovf",   int'(woverflow), 0);

    // fill with the read pointer parked at zero
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b0, 1'b1, 5'd0);
      chk("fill_waddr", int'(waddr), k);
      chk("fill_wen",   int'(wen),   1);
      if (k < 5) chk("fill_wptr", int'(wptr), int'(gtab[k]));
      if (k == AFULL - 1) chk("fill_afull_pre", int'(walmost_full), 0);
      if (k == AFULL)     chk("fill_afull",     int'(walmost_full), 1);
    end

    // overflow attempts while full
    cycle(1'b0, 1'b1, 5'd0);
    chk("full_wfull",  int'(wfull),     1);
    chk("full_wlevel", int'(wlevel),    16);
    chk("full_wptr",   int'(wptr),      int'(5'b11000));
    chk("ovf_wen",     int'(wen),       0);
    chk("ovf_pre",     int'(woverflow), 0);
    for (int j = 0; j < 2; j++) begin
      cycle(1'b0, 1'b1, 5'd0);
      chk("ovf_wen",  int'(wen),       0);
      chk("ovf_wptr", int'(wptr),      int'(5'b11000));
      chk("ovf_flag", int'(woverflow), 1);
    end
    cycle(1'b0, 1'b0, 5'd0);
    chk("ovf_sticky", int'(woverflow), 1);
    chk("ovf_wptr",   int'(wptr),      int'(5'b11000));
    chk("ovf_wlevel", int'(wlevel),    16);

    // write while full and read pointer advances in the same cycle
    cycle(1'b0, 1'b1, 5'b00001);
    chk("sim_wen", int'(wen), 0);
    cycle(1'b0, 1'b0, 5'b00001);
    chk("sim_wfull",  int'(wfull),  0);
    chk("sim_wlevel", int'(wlevel), DEPTH - 1);
    chk("sim_wptr",   int'(wptr),   int'(5'b11000));

    // read pointer jumps to Gray(5)
    cycle(1'b0, 1'b0, 5'b00111);
    cycle(1'b0, 1'b1, 5'b00111);
    chk("drain_wfull",  int'(wfull),        0);
    chk("drain_wlevel", int'(wlevel),       11);
    chk("drain_afull",  int'(walmost_full), 0);
    chk("drain_wen",    int'(wen),          1);
    cycle(1'b0, 1'b0, 5'b00111);
    chk("drain_wlevel2", int'(wlevel),       12);
    chk("drain_afull2",  int'(walmost_full), 1);
    chk("drain_ovf",     int'(woverflow),    1);

    // reset in the middle of a fill
    cycle(1'b1, 1'b0, 5'd0);
    cycle(1'b0, 1'b0, 5'd0);
    chk("rst_clears_ovf", int'(woverflow), 0);
    chk("rst_clears_ptr", int'(wptr),      0);
    for (int k = 0; k < 7; k++) cycle(1'b0, 1'b1, 5'd0);
    cycle(1'b1, 1'b1, 5'd0);
    chk("mid_wen",       int'(wen),   0);
    chk("mid_waddr_pre", int'(waddr), 7);
    cycle(1'b0, 1'b1, 5'd0);
    chk("mid_wptr",   int'(wptr),         0);
    chk("mid_wlevel", int'(wlevel),       0);
    chk("mid_wfull",  int'(wfull),        0);
    chk("mid_afull",  int'(walmost_full), 0);
    chk("mid_waddr",  int'(waddr),        0);
    chk("mid_wen2",   int'(wen),          1);
    cycle(1'b0, 1'b0, 5'd0);
    chk("mid_wptr_after",  int'(wptr),  1);
    chk("mid_waddr_after", int'(waddr), 1);

    // wrap with the read pointer trailing the write pointer
    cycle(1'b1, 1'b0, 5'd0);
    cycle(1'b0, 1'b0, 5'd0);
    cycle(1'b0, 1'b0, 5'd0);
    track = 1'b1;
    prev  = wptr;
    for (int n = 0; n < 40; n++) begin
      cycle(1'b0, 1'b1, 5'd0);
      if (n > 0) chk("wrap_toggle", $countones(wptr ^ prev), 1);
      prev = wptr;
      chk("wrap_nofull",    int'(wfull),       0);
      chk("wrap_level_le2", int'(wlevel <= 2), 1);
      if (n == 31) chk("wrap_wptr31", int'(wptr), int'(5'b10000));
      if (n == 32) chk("wrap_wptr32", int'(wptr), 0);
    end
    cycle(1'b0, 1'b0, 5'd0);
    chk("wrap_final", int'(wptr), int'(5'b01100));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
